text_ram_ctrl: RTL and testbench

TEXT_RAM_CTRL -- requirements
Module: text_ram_ctrl

---
 rtl/text_ram_ctrl.sv | 171 +++++++++++++++++
 tb/tb_text_ram_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/text_ram_ctrl.sv
// Text-mode character RAM write controller: editor write slot, clear-screen sweep, cursor highlight.
// Optional cursor blinking is compiled in with `define CURSOR_BLINK_EN.
module text_ram_ctrl #(
   parameter int          COLS         = 80,
   parameter int          ROWS         = 60,
   parameter logic [6:0]  FILL_CHAR    = 7'h20,
   parameter logic [23:0] BLINK_PERIOD = 24'd12582912
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ed_req,
   input  logic [6:0] ed_x,
   input  logic [5:0] ed_y,
   input  logic [6:0] ed_char,
   input  logic [5:0] ed_col,
   output logic       ed_ovf,
   input  logic       clr_start,
   input  logic [5:0] clr_col,
   output logic       clr_busy,
   output logic [6:0] ram_x,
   output logic [5:0] ram_y,
   output logic [6:0] ram_char,
   output logic [5:0] ram_col,
   output logic       ram_wren,
   input  logic [6:0] cur_x,
   input  logic [5:0] cur_y,
   output logic [6:0] hl_x,
   output logic [5:0] hl_y,
   output logic       hl_on
);

   localparam logic [6:0] LAST_X = 7'(COLS - 1);
   localparam logic [5:0] LAST_Y = 6'(ROWS - 1);

   typedef enum logic [1:0] {IDLE, ED_WR, CLEAR} state_t;

   state_t     state, state_n;
   logic       slot_full;
   logic [6:0] slot_x, slot_char;
   logic [5:0] slot_y, slot_col;
   logic       clr_pend, clr_pend_n, clr_accept;
   logic [5:0] clr_col_q;
   logic [6:0] cx;
   logic [5:0] cy;
   logic       drain;

   always_comb begin
      state_n    = state;
      drain      = 1'b0;
      clr_accept = clr_start && !clr_busy && !clr_pend;
      clr_pend_n = clr_pend;
      case (state)
         IDLE: begin
            if (slot_full) begin
               state_n = ED_WR;
               drain   = 1'b1;
            end else if (clr_pend) begin
               state_n    = CLEAR;
               clr_pend_n = 1'b0;
            end
         end
         ED_WR:   state_n = IDLE;
         CLEAR:   if (cx == LAST_X && cy == LAST_Y) state_n = IDLE;
         default: state_n = IDLE;
      endcase
      if (clr_accept) clr_pend_n = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         slot_full <= 1'b0;
         slot_x    <= '0;
         slot_y    <= '0;
         slot_char <= '0;
         slot_col  <= '0;
         clr_pend  <= 1'b0;
         clr_col_q <= '0;
         clr_busy  <= 1'b0;
         cx        <= '0;
         cy        <= '0;
         ed_ovf    <= 1'b0;
         ram_wren  <= 1'b0;
         ram_x     <= '0;
         ram_y     <= '0;
         ram_char  <= '0;
         ram_col   <= '0;
      end else begin
         state    <= state_n;
         clr_pend <= clr_pend_n;
         clr_busy <= clr_pend_n || (state_n == CLEAR) || (state == CLEAR);
         ed_ovf   <= ed_req && slot_full && !drain;
         if (clr_accept) clr_col_q <= clr_col;

         if (ed_req && (!slot_full || drain)) begin
            slot_full <= 1'b1;
            slot_x    <= ed_x;
            slot_y    <= ed_y;
            slot_char <= ed_char;
            slot_col  <= ed_col;
         end else if (drain) begin
            slot_full <= 1'b0;
         end

         if (state == CLEAR) begin
            if (cx == LAST_X) begin
               cx <= '0;
               cy <= (cy == LAST_Y) ? '0 : cy + 6'd1;
            end else begin
               cx <= cx + 7'd1;
            end
         end else begin
            cx <= '0;
            cy <= '0;
         end

         // The editor write is registered on the edge entering ED_WR, so it is visible during ED_WR.
         ram_wren <= 1'b0;
         if (drain) begin
            ram_x    <= slot_x;
            ram_y    <= slot_y;
            ram_char <= slot_char;
            ram_col  <= slot_col;
            ram_wren <= (slot_x <= LAST_X) && (slot_y <= LAST_Y);
         end else if (state == CLEAR) begin
            ram_x    <= cx;
            ram_y    <= cy;
            ram_char <= FILL_CHAR;
            ram_col  <= clr_col_q;
            ram_wren <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hl_x <= '0;
         hl_y <= '0;
      end else begin
         hl_x <= cur_x;
         hl_y <= cur_y;
      end
   end

`ifdef CURSOR_BLINK_EN
   localparam logic [23:0] BLINK_RELOAD = BLINK_PERIOD - 24'd1;
   logic [23:0] blink_cnt;

   // hl_x/hl_y hold last cycle's cursor, so a mismatch means the cursor just moved.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blink_cnt <= BLINK_RELOAD;
         hl_on     <= 1'b1;
      end else if (cur_x != hl_x || cur_y != hl_y) begin
         blink_cnt <= BLINK_RELOAD;
         hl_on     <= 1'b1;
      end else if (blink_cnt == '0) begin
         blink_cnt <= BLINK_RELOAD;
         hl_on     <= !hl_on;
      end else begin
         blink_cnt <= blink_cnt - 24'd1;
      end
   end
`else
   always_ff @(posedge clk or posedge reset) begin
      if (reset) hl_on <= 1'b1;
      else       hl_on <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_text_ram_ctrl.sv
// Directed bench for text_ram_ctrl: editor write table, clear sweeps, overflow, reset abort, cursor highlight.
module tb_text_ram_ctrl;
   localparam int COLS = 80;
   localparam int ROWS = 60;

   logic       clk = 1'b0;
   logic       reset;
   logic       ed_req, clr_start;
   logic [6:0] ed_x, ed_char, cur_x;
   logic [5:0] ed_y, ed_col, clr_col, cur_y;
   logic       ed_ovf, clr_busy, ram_wren, hl_on;
   logic [6:0] ram_x, ram_char, hl_x;
   logic [5:0] ram_y, ram_col, hl_y;

   always #5 clk = ~clk;

   text_ram_ctrl #(
      .COLS(COLS), .ROWS(ROWS), .FILL_CHAR(7'h20), .BLINK_PERIOD(24'd4)
   ) dut (
      .clk(clk), .reset(reset),
      .ed_req(ed_req), .ed_x(ed_x), .ed_y(ed_y), .ed_char(ed_char), .ed_col(ed_col),
      .ed_ovf(ed_ovf), .clr_start(clr_start), .clr_col(clr_col), .clr_busy(clr_busy),
      .ram_x(ram_x), .ram_y(ram_y), .ram_char(ram_char), .ram_col(ram_col), .ram_wren(ram_wren),
      .cur_x(cur_x), .cur_y(cur_y), .hl_x(hl_x), .hl_y(hl_y), .hl_on(hl_on)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   typedef struct {
      logic [6:0] x;
      logic [5:0] y;
      logic [6:0] ch;
      logic [5:0] col;
      logic       wren;
   } vec_t;
   vec_t vecs[7];

   // results of watch_clear
   int m_clr, m_bad, m_ovf, m_ed_pos, m_ed_x, m_ed_y, m_ed_ch;
   int m_fx, m_fy, m_lx, m_ly, m_busy_last, m_wren_done, m_done;

   task automatic watch_clear(input int inj, input int col);
      int ex, ey;
      ex = 0; ey = 0;
      m_clr = 0; m_bad = 0; m_ovf = 0; m_ed_pos = -1; m_done = 0;
      m_fx = -1; m_fy = -1; m_lx = -1; m_ly = -1; m_busy_last = 0; m_wren_done = 0;
      for (int i = 0; i < 6000 && m_done == 0; i++) begin
         @(negedge clk);
         clr_start = 1'b0;
         ed_req    = (inj >= 0) && (i >= inj) && (i < inj + 3);
         if (ed_ovf) m_ovf++;
         if (ram_wren) begin
            if (ram_char == 7'h20) begin
               if (int'(ram_x) != ex || int'(ram_y) != ey || int'(ram_col) != col) m_bad++;
               if (m_clr == 0) begin m_fx = int'(ram_x); m_fy = int'(ram_y); end
               m_lx = int'(ram_x); m_ly = int'(ram_y);
               m_busy_last = int'(clr_busy);
               m_clr++;
               if (ex == COLS - 1) begin ex = 0; ey++; end else ex++;
            end else begin
               m_ed_pos = m_clr;
               m_ed_x = int'(ram_x); m_ed_y = int'(ram_y); m_ed_ch = int'(ram_char);
            end
         end
         if (!clr_busy) begin
            m_done      = 1;
            m_wren_done = int'(ram_wren);
         end
      end
      ed_req = 1'b0;
   endtask

   initial begin
      int nw;
      vecs[0] = '{7'd3,   6'd5,  7'h41, 6'h3F, 1'b1};
      vecs[1] = '{7'd0,   6'd0,  7'h7E, 6'h00, 1'b1};
      vecs[2] = '{7'd79,  6'd59, 7'h5A, 6'h15, 1'b1};
      vecs[3] = '{7'd80,  6'd0,  7'h41, 6'h01, 1'b0};
      vecs[4] = '{7'd0,   6'd60, 7'h41, 6'h01, 1'b0};
      vecs[5] = '{7'd127, 6'd63, 7'h41, 6'h01, 1'b0};
      vecs[6] = '{7'd79,  6'd0,  7'h30, 6'h2A, 1'b1};

      reset = 1'b1; ed_req = 1'b0; clr_start = 1'b0;
      ed_x = '0; ed_y = '0; ed_char = '0; ed_col = '0; clr_col = '0; cur_x = '0; cur_y = '0;
      @(negedge clk); @(negedge clk);
      chk("rst_wren", int'(ram_wren), 0);
      chk("rst_ram_x", int'(ram_x), 0);
      chk("rst_ram_char", int'(ram_char), 0);
      chk("rst_busy", int'(clr_busy), 0);
      chk("rst_ovf", int'(ed_ovf), 0);
      chk("rst_hl_on", int'(hl_on), 1);
      reset = 1'b0;
      @(negedge clk);

      // editor write table: strobe, then wren exactly in the second sample
      for (int v = 0; v < 7; v++) begin
         ed_req = 1'b1; ed_x = vecs[v].x; ed_y = vecs[v].y; ed_char = vecs[v].ch; ed_col = vecs[v].col;
         @(negedge clk);
         ed_req = 1'b0;
         chk($sformatf("v%0d_wren_early", v), int'(ram_wren), 0);
         @(negedge clk);
         chk($sformatf("v%0d_wren", v), int'(ram_wren), int'(vecs[v].wren));
         if (vecs[v].wren) begin
            chk($sformatf("v%0d_x", v), int'(ram_x), int'(vecs[v].x));
            chk($sformatf("v%0d_y", v), int'(ram_y), int'(vecs[v].y));
            chk($sformatf("v%0d_char", v), int'(ram_char), int'(vecs[v].ch));
            chk($sformatf("v%0d_col", v), int'(ram_col), int'(vecs[v].col));
         end
         @(negedge clk);
         chk($sformatf("v%0d_wren_after", v), int'(ram_wren), 0);
      end

      // editor and clear in the same cycle: editor first, then full sweep
      ed_req = 1'b1; ed_x = 7'd1; ed_y = 6'd2; ed_char = 7'h55; ed_col = 6'd4;
      clr_start = 1'b1; clr_col = 6'd9;
      watch_clear(-1, 9);
      chk("tie_done", m_done, 1);
      chk("tie_ed_pos", m_ed_pos, 0);
      chk("tie_ed_char", m_ed_ch, 'h55);
      chk("tie_clr_count", m_clr, COLS * ROWS);
      chk("tie_clr_bad", m_bad, 0);

      // plain clear sweep
      @(negedge clk);
      clr_start = 1'b1; clr_col = 6'h01;
      watch_clear(-1, 1);
      chk("clr_done", m_done, 1);
      chk("clr_count", m_clr, 4800);
      chk("clr_bad", m_bad, 0);
      chk("clr_first_x", m_fx, 0);
      chk("clr_first_y", m_fy, 0);
      chk("clr_last_x", m_lx, 79);
      chk("clr_last_y", m_ly, 59);
      chk("clr_busy_at_last", m_busy_last, 1);
      chk("clr_wren_at_fall", m_wren_done, 0);
      chk("clr_no_editor", m_ed_pos, -1);

      // three editor strobes during a sweep: one buffered, two dropped
      @(negedge clk);
      ed_x = 7'd7; ed_y = 6'd8; ed_char = 7'h42; ed_col = 6'd2;
      clr_start = 1'b1; clr_col = 6'd5;
      watch_clear(50, 5);
      chk("ovf_count", m_ovf, 2);
      chk("ovf_clr_count", m_clr, 4800);
      chk("ovf_clr_bad", m_bad, 0);
      chk("ovf_ed_pos", m_ed_pos, 4800);
      chk("ovf_ed_x", m_ed_x, 7);
      chk("ovf_ed_y", m_ed_y, 8);
      chk("ovf_ed_char", m_ed_ch, 'h42);
      @(negedge clk);
      chk("ovf_wren_after", int'(ram_wren), 0);

      // reset while sweeping at cell 100
      clr_start = 1'b1; clr_col = 6'd3;
      nw = 0;
      for (int i = 0; i < 400 && nw < 100; i++) begin
         @(negedge clk);
         clr_start = 1'b0;
         if (ram_wren) nw++;
      end
      chk("abort_reached", nw, 100);
      reset = 1'b1;
      #1;
      chk("abort_wren", int'(ram_wren), 0);
      chk("abort_x", int'(ram_x), 0);
      chk("abort_y", int'(ram_y), 0);
      chk("abort_col", int'(ram_col), 0);
      chk("abort_busy", int'(clr_busy), 0);
      chk("abort_hl_on", int'(hl_on), 1);
      @(negedge clk);
      reset = 1'b0;
      nw = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (ram_wren || clr_busy) nw++;
      end
      chk("abort_quiet", nw, 0);

      // cursor highlight
      cur_x = 7'd5; cur_y = 6'd3;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 0) begin
            chk("hl_x", int'(hl_x), 5);
            chk("hl_y", int'(hl_y), 3);
         end
`ifdef CURSOR_BLINK_EN
         chk($sformatf("blink_a%0d", i), int'(hl_on), ((i / 4) % 2 == 0) ? 1 : 0);
`else
         chk($sformatf("steady_a%0d", i), int'(hl_on), 1);
`endif
      end
      cur_y = 6'd4;
      for (int j = 0; j < 10; j++) begin
         @(negedge clk);
         if (j == 0) chk("hl_y_moved", int'(hl_y), 4);
`ifdef CURSOR_BLINK_EN
         chk($sformatf("blink_b%0d", j), int'(hl_on), ((j / 4) % 2 == 0) ? 1 : 0);
`else
         chk($sformatf("steady_b%0d", j), int'(hl_on), 1);
`endif
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
